// File: rtl/stb_fwd_queue.sv
// Store buffer: circular queue of pending stores drained to the dcache in order.
// Define STB_FWD_EN to add same-cycle store-to-load byte forwarding.
module stb_fwd_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_wdata,
  input  logic [DATA_W/8-1:0]          push_sel_byte,
  output logic                         stb_valid,
  input  logic                         stb_ready,
  output logic [ADDR_W-1:0]            stb_addr,
  output logic [DATA_W-1:0]            stb_wdata,
  output logic [DATA_W/8-1:0]          stb_sel_byte,
  input  logic                         ld_req,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [DATA_W/8-1:0]          ld_sel_byte,
  output logic                         fwd_hit,
  output logic                         fwd_partial,
  output logic [DATA_W-1:0]            fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   stb_count,
  output logic                         stb_full,
  output logic                         stb_empty
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DEPTH-1:0]  valid_reg;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   sel_mem  [DEPTH];

  logic push_fire;
  logic pop_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stb_full   = (count_reg == CNT_W'(DEPTH));
  assign stb_empty  = (count_reg == '0);
  assign push_ready = !stb_full;
  assign stb_valid  = !stb_empty;
  assign stb_count  = count_reg;

  assign push_fire = push_valid && push_ready;
  assign pop_fire  = stb_valid && stb_ready;

  // Push and pop never target the same slot: that would need empty and full at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_reg            <= ptr_inc(wr_ptr_reg);
        valid_reg[wr_ptr_reg] <= 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_reg            <= ptr_inc(rd_ptr_reg);
        valid_reg[rd_ptr_reg] <= 1'b0;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by valid_reg alone.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_wdata;
      sel_mem[wr_ptr_reg]  <= push_sel_byte;
    end
  end

  assign stb_addr     = stb_empty ? '0 : addr_mem[rd_ptr_reg];
  assign stb_wdata    = stb_empty ? '0 : data_mem[rd_ptr_reg];
  assign stb_sel_byte = stb_empty ? '0 : sel_mem[rd_ptr_reg];

`ifdef STB_FWD_EN
  localparam int OFF_W = $clog2(BE_W);
  localparam int SUM_W = PTR_W + 1;

  // age_idx[0] is the oldest slot, age_idx[DEPTH-1] the youngest possible one.
  logic [PTR_W-1:0] age_idx [DEPTH];
  logic [BE_W-1:0]   cov_bytes;
  logic [DATA_W-1:0] cov_data;
  logic              unused_ld;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [SUM_W-1:0] sum;
    assign sum = {1'b0, rd_ptr_reg} + SUM_W'(gi);
    assign age_idx[gi] = (sum >= SUM_W'(DEPTH)) ? PTR_W'(sum - SUM_W'(DEPTH))
                                                : sum[PTR_W-1:0];
  end

  // Walk oldest to youngest so a younger matching byte overwrites an older one.
  always_comb begin
    cov_bytes = '0;
    cov_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_reg[age_idx[k]] &&
          addr_mem[age_idx[k]][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (sel_mem[age_idx[k]][b] && ld_sel_byte[b]) begin
            cov_bytes[b]       = 1'b1;
            cov_data[8*b +: 8] = data_mem[age_idx[k]][8*b +: 8];
          end
        end
      end
    end
  end

  assign fwd_hit     = ld_req && (ld_sel_byte != '0) && (cov_bytes == ld_sel_byte);
  assign fwd_partial = ld_req && (cov_bytes != '0) && (cov_bytes != ld_sel_byte);
  assign fwd_data    = ld_req ? cov_data : '0;
  assign unused_ld   = ^ld_addr;
`else
  logic unused_ld;
  assign fwd_hit     = 1'b0;
  assign fwd_partial = 1'b0;
  assign fwd_data    = '0;
  assign unused_ld   = ^{ld_req, ld_addr, ld_sel_byte};
`endif

endmodule

// File: tb/tb_stb_fwd_queue.sv
// Randomized and directed bench for stb_fwd_queue against a queue-based reference model.
// Forwarding expectations follow whether STB_FWD_EN is defined for the build.
module tb_stb_fwd_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic        rst, push_valid, stb_ready, ld_req;
  logic [31:0] push_addr, push_wdata, ld_addr;
  logic [3:0]  push_sel_byte, ld_sel_byte;
  logic        push_ready, stb_valid, fwd_hit, fwd_partial, stb_full, stb_empty;
  logic [31:0] stb_addr, stb_wdata, fwd_data;
  logic [3:0]  stb_sel_byte;
  logic [2:0]  stb_count;

  // DEPTH=3 instance
  logic        rst3, push_valid3, stb_ready3;
  logic [31:0] push_addr3, push_wdata3;
  logic [3:0]  push_sel_byte3;
  logic        ld_req3;
  logic [31:0] ld_addr3;
  logic [3:0]  ld_sel_byte3;
  logic        push_ready3, stb_valid3, fwd_hit3, fwd_partial3, stb_full3, stb_empty3;
  logic [31:0] stb_addr3, stb_wdata3, fwd_data3;
  logic [3:0]  stb_sel_byte3;
  logic [1:0]  stb_count3;

  stb_fwd_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
    .push_wdata(push_wdata), .push_sel_byte(push_sel_byte),
    .stb_valid(stb_valid), .stb_ready(stb_ready), .stb_addr(stb_addr),
    .stb_wdata(stb_wdata), .stb_sel_byte(stb_sel_byte),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_sel_byte(ld_sel_byte),
    .fwd_hit(fwd_hit), .fwd_partial(fwd_partial), .fwd_data(fwd_data),
    .stb_count(stb_count), .stb_full(stb_full), .stb_empty(stb_empty)
  );

  stb_fwd_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst3),
    .push_valid(push_valid3), .push_ready(push_ready3), .push_addr(push_addr3),
    .push_wdata(push_wdata3), .push_sel_byte(push_sel_byte3),
    .stb_valid(stb_valid3), .stb_ready(stb_ready3), .stb_addr(stb_addr3),
    .stb_wdata(stb_wdata3), .stb_sel_byte(stb_sel_byte3),
    .ld_req(ld_req3), .ld_addr(ld_addr3), .ld_sel_byte(ld_sel_byte3),
    .fwd_hit(fwd_hit3), .fwd_partial(fwd_partial3), .fwd_data(fwd_data3),
    .stb_count(stb_count3), .stb_full(stb_full3), .stb_empty(stb_empty3)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t q[$];
  ent_t q3[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest store to the same word wins, byte by byte.
  function automatic void fwd_exp(output logic h, output logic p, output logic [31:0] d);
    logic [3:0] cov;
    cov = '0;
    d   = '0;
    h   = 1'b0;
    p   = 1'b0;
`ifdef STB_FWD_EN
    if (ld_req) begin
      for (int b = 0; b < 4; b++) begin
        if (ld_sel_byte[b]) begin
          for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a[31:2] == ld_addr[31:2] && q[i].s[b]) begin
              cov[b]       = 1'b1;
              d[8*b +: 8]  = q[i].d[8*b +: 8];
              break;
            end
          end
        end
      end
      h = (ld_sel_byte != 0) && (cov == ld_sel_byte);
      p = (cov != 0) && (cov != ld_sel_byte);
    end
`endif
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic step(input bit do_chk);
    logic       eh, ep;
    logic [31:0] ed;
    bit         do_pop, do_push;
    #1;
    if (do_chk) begin
      fwd_exp(eh, ep, ed);
      chk("count",      stb_count,  q.size());
      chk("full",       stb_full,   q.size() == 4);
      chk("empty",      stb_empty,  q.size() == 0);
      chk("push_ready", push_ready, q.size() < 4);
      chk("stb_valid",  stb_valid,  q.size() > 0);
      chk("head_addr",  stb_addr,     q.size() > 0 ? q[0].a : 32'h0);
      chk("head_data",  stb_wdata,    q.size() > 0 ? q[0].d : 32'h0);
      chk("head_sel",   stb_sel_byte, q.size() > 0 ? q[0].s : 4'h0);
      chk("fwd_hit",     fwd_hit,     eh);
      chk("fwd_partial", fwd_partial, ep);
      chk("fwd_data",    fwd_data,    ed);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && stb_ready;
      do_push = push_valid && (q.size() < 4);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{push_addr, push_wdata, push_sel_byte});
    end
    @(negedge clk);
  endtask

  task automatic step3();
    bit do_pop, do_push;
    #1;
    chk("d3_count",     stb_count3, q3.size());
    chk("d3_full",      stb_full3,  q3.size() == 3);
    chk("d3_valid",     stb_valid3, q3.size() > 0);
    chk("d3_head_data", stb_wdata3, q3.size() > 0 ? q3[0].d : 32'h0);
    chk("d3_head_addr", stb_addr3,  q3.size() > 0 ? q3[0].a : 32'h0);
    @(posedge clk);
    if (rst3) begin
      q3.delete();
    end else begin
      do_pop  = (q3.size() > 0) && stb_ready3;
      do_push = push_valid3 && (q3.size() < 3);
      if (do_pop)  void'(q3.pop_front());
      if (do_push) q3.push_back('{push_addr3, push_wdata3, push_sel_byte3});
    end
    @(negedge clk);
  endtask

  task automatic set_push(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    push_valid    = v;
    push_addr     = a;
    push_wdata    = d;
    push_sel_byte = s;
  endtask

  task automatic set_load(input logic r, input logic [31:0] a, input logic [3:0] s);
    ld_req      = r;
    ld_addr     = a;
    ld_sel_byte = s;
  endtask

  logic [31:0] exp33, addr_pool [4], ld_pool [4];
  logic [31:0] head_before;

  initial begin
    addr_pool = '{32'h100, 32'h104, 32'h200, 32'h102};
    ld_pool   = '{32'h100, 32'h101, 32'h204, 32'h200};
    rst = 1'b1; stb_ready = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 4'h0);
    set_load(1'b0, 32'h0, 4'h0);
    rst3 = 1'b1; push_valid3 = 1'b0; stb_ready3 = 1'b0;
    push_addr3 = '0; push_wdata3 = '0; push_sel_byte3 = '0;
    ld_req3 = 1'b0; ld_addr3 = '0; ld_sel_byte3 = '0;

    // Reset: first edge establishes state, second cycle checks it.
    step(1'b0);
    set_load(1'b1, 32'h100, 4'hF);
    step(1'b1);
    rst = 1'b0;
    set_load(1'b0, 32'h0, 4'h0);
    step(1'b1);

    // Fill to full with the dcache stalled, then try a fifth push.
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'h40 + 32'(i * 4), $urandom, 4'hF);
      step(1'b1);
    end
    chk("fill_count", stb_count, 3'd4);
    chk("fill_full",  stb_full, 1'b1);
    chk("fill_ready", push_ready, 1'b0);
    head_before = stb_wdata;
    set_push(1'b1, 32'h80, 32'hDEADBEEF, 4'hF);
    step(1'b1);
    chk("drop_count", stb_count, 3'd4);
    chk("drop_head",  stb_wdata, head_before);

    // Push and pop together while full: only the pop happens.
    stb_ready = 1'b1;
    step(1'b1);
    chk("fullpop_count", stb_count, 3'd3);
    stb_ready = 1'b0;
    step(1'b1);
    chk("refill_count", stb_count, 3'd4);

    // Forwarding merge from two stores to the same word.
    rst = 1'b1; set_push(1'b0, 32'h0, 32'h0, 4'h0);
    step(1'b1);
    rst = 1'b0;
    set_push(1'b1, 32'h100, 32'hAABBCCDD, 4'b1111);
    step(1'b1);
    set_push(1'b1, 32'h100, 32'h11223344, 4'b0011);
    step(1'b1);
    set_push(1'b0, 32'h0, 32'h0, 4'h0);
    set_load(1'b1, 32'h100, 4'b1111);
    #1;
`ifdef STB_FWD_EN
    exp33 = 32'hAABB3344;
    chk("merge_hit", fwd_hit, 1'b1);
`else
    exp33 = 32'h0;
    chk("merge_hit", fwd_hit, 1'b0);
`endif
    chk("merge_data", fwd_data, exp33);
    chk("merge_count", stb_count, 3'd2);
    step(1'b1);

    // Partial coverage.
    set_push(1'b1, 32'h200, 32'h000000EE, 4'b0001);
    set_load(1'b0, 32'h0, 4'h0);
    step(1'b1);
    set_push(1'b0, 32'h0, 32'h0, 4'h0);
    set_load(1'b1, 32'h200, 4'b0011);
    #1;
`ifdef STB_FWD_EN
    chk("partial_flag", fwd_partial, 1'b1);
    chk("partial_data", fwd_data, 32'h000000EE);
`else
    chk("partial_flag", fwd_partial, 1'b0);
    chk("partial_data", fwd_data, 32'h0);
`endif
    chk("partial_hit", fwd_hit, 1'b0);
    step(1'b1);

    // Randomized traffic with loads probing the queue each cycle.
    for (int i = 0; i < 300; i++) begin
      set_push($urandom_range(0, 2) != 0, addr_pool[$urandom_range(0, 3)], $urandom,
               4'($urandom_range(1, 15)));
      stb_ready = ($urandom_range(0, 2) == 0);
      set_load($urandom_range(0, 3) != 0, ld_pool[$urandom_range(0, 3)],
               4'($urandom_range(1, 15)));
      step(1'b1);
    end

    // Reset mid-stream with a push and pop pending.
    set_push(1'b1, 32'h100, 32'h12345678, 4'hF);
    stb_ready = 1'b1;
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 4'h0);
    stb_ready = 1'b0;
    chk("midrst_empty", stb_empty, 1'b1);
    step(1'b1);

    // DEPTH=3: push/pop pairs wrap the pointers several times.
    step3();
    rst3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_valid3    = 1'b1;
      push_addr3     = 32'h300 + 32'(i * 4);
      push_wdata3    = $urandom;
      push_sel_byte3 = 4'hF;
      stb_ready3     = 1'b1;
      step3();
    end
    chk("d3_pairs_count", stb_count3, 2'd1);
    for (int i = 0; i < 5; i++) begin
      push_valid3 = ($urandom_range(0, 1) == 1);
      push_wdata3 = $urandom;
      stb_ready3  = (i == 4) ? 1'b1 : 1'b0;
      step3();
    end
    rst3 = 1'b1;
    push_valid3 = 1'b1;
    step3();
    rst3 = 1'b0;
    push_valid3 = 1'b0;
    chk("d3_rst_empty", stb_empty3, 1'b1);
    step3();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stb_fwd_queue.md
STB_FWD_QUEUE -- requirements
Module: stb_fwd_queue

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ADDR_W, 32: store address width.
- DATA_W, 32: data width; byte-enable width BE_W = DATA_W/8; DATA_W is a multiple of 8.
- DEPTH, 4: number of entries; any value >= 2, not restricted to powers of two.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 push_valid  in  1  LSU/MMU store request.
REQ-005 push_ready  out  1  entry available; equals !stb_full.
REQ-006 push_addr  in  ADDR_W  store address; push_wdata  in  DATA_W  store data; push_sel_byte  in  BE_W  byte enables.
REQ-007 stb_valid  out  1  oldest entry presented to dcache; equals !stb_empty.
REQ-008 stb_ready  in  1  dcache accepts the presented entry.
REQ-009 stb_addr  out  ADDR_W; stb_wdata  out  DATA_W; stb_sel_byte  out  BE_W: head entry, all zero when stb_empty.
REQ-010 ld_req  in  1; ld_addr  in  ADDR_W; ld_sel_byte  in  BE_W: load lookup for forwarding.
REQ-011 fwd_hit  out  1; fwd_partial  out  1; fwd_data  out  DATA_W: forwarding result.
REQ-012 stb_count  out  $clog2(DEPTH+1): current occupancy.
REQ-013 stb_full  out  1; stb_empty  out  1.

Function
REQ-014 Circular queue: wr_ptr and rd_ptr in [0, DEPTH-1]; each wraps from DEPTH-1 to 0. Full/empty come from stb_count, not from pointer comparison, so all DEPTH entries are usable.
REQ-015 Push fires when push_valid && push_ready. On a push, the entry is written at wr_ptr and is visible at the head no earlier than the next cycle (no same-cycle bypass).
REQ-016 Pop fires when stb_valid && stb_ready. On a pop, rd_ptr advances in the same cycle; head outputs are combinational from rd_ptr.
REQ-017 Simultaneous push and pop when full: push_ready is 0, so only the pop occurs; the count decrements.
REQ-018 Simultaneous push and pop when not full and not empty: both occur; stb_count is unchanged.
REQ-019 stb_count increments on push only, decrements on pop only, and never exceeds DEPTH or goes below 0.
REQ-020 Push attempts while full are ignored and have no side effects. stb_ready while empty is ignored.
REQ-021 Head outputs remain stable while stb_valid && !stb_ready.
REQ-022 Forwarding is combinational in the same cycle as ld_req. Only valid entries are considered. Word match: addr[ADDR_W-1:$clog2(BE_W)] equal.
REQ-023 For each byte set in ld_sel_byte, the data comes from the youngest matching entry with that byte enabled.
REQ-024 fwd_hit=1 when every requested byte is covered. fwd_partial=1 when some, but not all, requested bytes are covered.
REQ-025 Bytes of fwd_data that are not covered read 0. When ld_req=0, fwd_hit, fwd_partial and fwd_data are 0.
REQ-026 An entry popped in the current cycle still participates in forwarding. An entry pushed in the current cycle does not.

Reset
REQ-027 While rst=1 at a clock edge, the following are cleared: wr_ptr, rd_ptr, stb_count, and all entry valid bits. After reset: stb_empty=1, stb_full=0, push_ready=1, stb_valid=0, head outputs 0, forwarding outputs 0.
REQ-028 Reset overrides any push or pop in the same cycle. Pending entries are discarded.
REQ-029 Entry data and address arrays need not be reset.

Configuration
REQ-030 Macro STB_FWD_EN selects forwarding.
- Defined: REQ-022 to REQ-026 are implemented.
- Undefined: fwd_hit, fwd_partial and fwd_data are tied to 0, no comparators are synthesised, and ld_* inputs are ignored; queue behaviour is unchanged.

Verification
REQ-031 Reset, then push 4 stores with stb_ready=0 (DEPTH=4) -> stb_count=4, stb_full=1, push_ready=0; a 5th push is dropped.
REQ-032 Full queue, assert push_valid and stb_ready together -> only the pop occurs, stb_count=3; the next cycle push succeeds and stb_count=4.
REQ-033 Push 0x100/0xAABBCCDD/1111 then 0x100/0x11223344/0011; load 0x100 with sel 1111 -> fwd_hit=1, fwd_data=0xAABB3344.
REQ-034 Push 0x200/sel 0001; load 0x200 with sel 0011 -> fwd_partial=1, fwd_hit=0, fwd_data[15:8]=0.
REQ-035 DEPTH=3: 10 push/pop pairs -> pointers wrap and data is popped in FIFO order with no loss. Assert rst mid-stream -> empty next cycle.
REQ-036 Build without STB_FWD_EN, repeat REQ-033 -> fwd_hit=0, fwd_data=0; queue results match the forwarding build.
